// File: rtl/uart_cmd_decoder_if.sv
// Host-command bus bundle for the UART command decoder: receive strobe,
// framebuffer write port, response byte handshake and status outputs.
interface uart_cmd_decoder_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              overrun;
  logic [7:0]        err_count;

  // The decoder itself: consumes bytes, drives writes and responses.
  modport master (
    input  rx_data, rx_valid, wr_ready, tx_ready,
    output wr_en, wr_addr, wr_data, tx_data, tx_valid, overrun, err_count
  );

  // The surroundings: UART receiver/transmitter and framebuffer.
  modport slave (
    output rx_data, rx_valid, wr_ready, tx_ready,
    input  wr_en, wr_addr, wr_data, tx_data, tx_valid, overrun, err_count
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Host-to-video-memory command decoder. Frames UART bytes into packets
// (A5 CMD AH AL D [N] CK), verifies the XOR checksum, performs single or
// fill byte writes into the framebuffer and answers with ACK (06) or NAK (15).
module uart_cmd_decoder #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_cmd_decoder_if.master bus
);

  localparam int         CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_F = 8'h46;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [3:0] {
    IDLE, GET_CMD, GET_AH, GET_AL, GET_D, GET_N, GET_CK, EXEC, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        ah_q, ah_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [8:0]        count_q, count_d;
  logic [7:0]        xor_q, xor_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [7:0]        resp_q, resp_d;
  logic [7:0]        err_q, err_d;
  logic              ovr_q, ovr_d;
  logic              err_inc;
  logic              in_get;
  logic              timeout_hit;

  // State and datapath registers; reset clears everything, which also
  // drops the write request immediately because it decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      ah_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      xor_q   <= '0;
      idle_q  <= '0;
      resp_q  <= '0;
      err_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ah_q    <= ah_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      xor_q   <= xor_d;
      idle_q  <= idle_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: packet framing, checksum, write sequencing, the
  // inter-byte timeout (a byte arriving on the expiry cycle wins) and
  // the sticky overrun / saturating error bookkeeping.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ah_d    = ah_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    xor_d   = xor_q;
    idle_d  = '0;
    resp_d  = resp_q;
    ovr_d   = ovr_q;
    err_inc = 1'b0;

    in_get = state_q inside {GET_CMD, GET_AH, GET_AL, GET_D, GET_N, GET_CK};
    timeout_hit = in_get && !bus.rx_valid &&
                  (idle_q == CNT_W'(TIMEOUT_CYCLES - 1));

    if (in_get && !bus.rx_valid) begin
      idle_d = idle_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC) begin
          xor_d   = '0;
          state_d = GET_CMD;
        end
      end
      GET_CMD: begin
        if (bus.rx_valid) begin
          cmd_d   = bus.rx_data;
          xor_d   = xor_q ^ bus.rx_data;
          state_d = GET_AH;
        end
      end
      GET_AH: begin
        if (bus.rx_valid) begin
          ah_d    = bus.rx_data;
          xor_d   = xor_q ^ bus.rx_data;
          state_d = GET_AL;
        end
      end
      GET_AL: begin
        if (bus.rx_valid) begin
          addr_d  = ADDR_W'({ah_q, bus.rx_data});
          xor_d   = xor_q ^ bus.rx_data;
          state_d = GET_D;
        end
      end
      GET_D: begin
        if (bus.rx_valid) begin
          data_d  = bus.rx_data;
          xor_d   = xor_q ^ bus.rx_data;
          count_d = 9'd1;
          state_d = (cmd_q == CMD_F) ? GET_N : GET_CK;
        end
      end
      GET_N: begin
        if (bus.rx_valid) begin
          count_d = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          xor_d   = xor_q ^ bus.rx_data;
          state_d = GET_CK;
        end
      end
      GET_CK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == xor_q && (cmd_q == CMD_W || cmd_q == CMD_F)) begin
            state_d = EXEC;
          end else begin
            resp_d  = NAK;
            err_inc = 1'b1;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        if (bus.rx_valid) begin
          ovr_d = 1'b1;
        end
        if (bus.wr_ready) begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q - 9'd1;
          if (count_q == 9'd1) begin
            resp_d  = ACK;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rx_valid) begin
          ovr_d = 1'b1;
        end
        if (bus.tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      state_d = IDLE;
      err_inc = 1'b1;
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // Outputs decode straight from registered state so they fall with reset.
  always_comb begin
    bus.wr_en     = (state_q == EXEC);
    bus.wr_addr   = addr_q;
    bus.wr_data   = data_q;
    bus.tx_valid  = (state_q == RESP);
    bus.tx_data   = resp_q;
    bus.overrun   = ovr_q;
    bus.err_count = err_q;
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed packets from the test
// plan plus randomized packets scored against a packet-level reference model.
module tb_uart_cmd_decoder;

  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_cmd_decoder_if #(.ADDR_W(16)) bus ();

  uart_cmd_decoder #(.ADDR_W(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          err_model = 0;
  int          hold_err = 0;
  int          stab_err = 0;
  bit          rdy_random = 1'b0;
  logic [23:0] wr_q[$];
  logic [7:0]  rsp_q[$];
  logic [23:0] exp_wq[$];
  logic [7:0]  exp_rsp;
  logic [7:0]  pkt[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr  = '0;
  logic        prev_wait  = 1'b0;
  logic [7:0]  prev_tx    = '0;

  // Observe the DUT mid-cycle: log write transfers and accepted responses,
  // and flag any address or response change while the consumer stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en && bus.wr_ready) wr_q.push_back({bus.wr_addr, bus.wr_data});
      if (bus.tx_valid && bus.tx_ready) rsp_q.push_back(bus.tx_data);
      if (prev_stall && bus.wr_en && bus.wr_addr !== prev_addr) hold_err++;
      if (prev_wait && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_tx)) stab_err++;
      prev_stall = bus.wr_en && !bus.wr_ready;
      prev_wait  = bus.tx_valid && !bus.tx_ready;
    end else begin
      prev_stall = 1'b0;
      prev_wait  = 1'b0;
    end
    prev_addr = bus.wr_addr;
    prev_tx   = bus.tx_data;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_random) bus.wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic make_packet(input logic [7:0] cmd, input logic [7:0] ah, input logic [7:0] al,
                             input logic [7:0] d, input logic [7:0] n, input bit corrupt);
    logic [7:0] x;
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(cmd);
    pkt.push_back(ah);
    pkt.push_back(al);
    pkt.push_back(d);
    if (cmd == 8'h46) pkt.push_back(n);
    x = 8'h00;
    for (int i = 1; i < pkt.size(); i++) x = x ^ pkt[i];
    if (corrupt) x = x ^ 8'h5A;
    pkt.push_back(x);
  endtask

  // Reference model: interpret the whole packet and list the writes and
  // response byte it must produce.
  task automatic model_packet();
    logic [7:0]  x;
    logic [7:0]  cmd;
    logic [15:0] base;
    int          cnt;
    bit          ok;
    exp_wq.delete();
    cmd  = pkt[1];
    base = {pkt[2], pkt[3]};
    x    = 8'h00;
    for (int i = 1; i < pkt.size() - 1; i++) x = x ^ pkt[i];
    ok = (x == pkt[pkt.size() - 1]) && (cmd == 8'h57 || cmd == 8'h46);
    if (ok) begin
      cnt = 1;
      if (cmd == 8'h46) cnt = (pkt[5] == 8'h00) ? 256 : int'(pkt[5]);
      for (int i = 0; i < cnt; i++) exp_wq.push_back({16'(int'(base) + i), pkt[4]});
      exp_rsp = 8'h06;
    end else begin
      exp_rsp = 8'h15;
      if (err_model < 255) err_model++;
    end
  endtask

  task automatic wait_resp(input int budget);
    int c = 0;
    while (rsp_q.size() == 0 && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_wr_en(input int budget);
    int c = 0;
    while (bus.wr_en !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic compare_result(input string tag);
    int m;
    check_output({tag, "_rsp_count"}, rsp_q.size(), 1);
    if (rsp_q.size() > 0) check_output({tag, "_rsp_byte"}, rsp_q[0], exp_rsp);
    check_output({tag, "_write_count"}, wr_q.size(), exp_wq.size());
    m = (wr_q.size() < exp_wq.size()) ? wr_q.size() : exp_wq.size();
    for (int i = 0; i < m; i++) check_output({tag, "_write"}, wr_q[i], exp_wq[i]);
    check_output({tag, "_err_count"}, bus.err_count, err_model);
  endtask

  // Send the current packet (gap<0 means random inter-byte gaps), then
  // wait for the response and score against the model.
  task automatic apply_stimulus(input string tag, input int gap);
    int g;
    model_packet();
    wr_q.delete();
    rsp_q.delete();
    foreach (pkt[i]) begin
      send_byte(pkt[i]);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) tick();
    end
    wait_resp(3000);
    compare_result(tag);
  endtask

  // Directed test-plan steps followed by randomized packets.
  initial begin
    logic [7:0] rcmd;
    logic [7:0] rn;
    int         r;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.wr_ready = 1'b1;
    bus.tx_ready = 1'b1;
    #23;
    check_output("reset_wr_en", bus.wr_en, 0);
    check_output("reset_tx_valid", bus.tx_valid, 0);
    check_output("reset_tx_data", bus.tx_data, 0);
    check_output("reset_wr_addr", bus.wr_addr, 0);
    check_output("reset_wr_data", bus.wr_data, 0);
    check_output("reset_err", bus.err_count, 0);
    check_output("reset_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("[TB] single write");
    make_packet(8'h57, 8'h12, 8'h34, 8'h9C, 8'h00, 1'b0);
    apply_stimulus("single", 0);
    if (wr_q.size() > 0) check_output("single_explicit", wr_q[0], 24'h12349C);

    $display("[TB] fill with wrap and write backpressure");
    bus.wr_ready = 1'b0;
    make_packet(8'h46, 8'hFF, 8'hFE, 8'h3C, 8'h04, 1'b0);
    model_packet();
    wr_q.delete();
    rsp_q.delete();
    hold_err = 0;
    foreach (pkt[i]) send_byte(pkt[i]);
    wait_wr_en(20);
    check_output("fill_wr_en", bus.wr_en, 1);
    check_output("fill_addr0", bus.wr_addr, 16'hFFFE);
    tick();
    check_output("fill_addr0_hold", bus.wr_addr, 16'hFFFE);
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    check_output("fill_addr1", bus.wr_addr, 16'hFFFF);
    tick();
    check_output("fill_addr1_hold", bus.wr_addr, 16'hFFFF);
    bus.wr_ready = 1'b1;
    wait_resp(100);
    compare_result("fill");
    check_output("fill_hold_err", hold_err, 0);

    $display("[TB] bad checksum and unknown command");
    make_packet(8'h57, 8'h00, 8'h10, 8'hAA, 8'h00, 1'b0);
    pkt[pkt.size() - 1] = 8'h00;
    apply_stimulus("badck", 1);
    check_output("badck_err_abs", bus.err_count, 1);
    make_packet(8'h33, 8'h00, 8'h10, 8'hAA, 8'h00, 1'b0);
    apply_stimulus("badcmd", 0);
    check_output("badcmd_err_abs", bus.err_count, 2);

    $display("[TB] timeout and resync");
    rsp_q.delete();
    wr_q.delete();
    send_byte(8'hA5);
    send_byte(8'h57);
    repeat (TMO + 5) tick();
    err_model++;
    check_output("timeout_no_rsp", rsp_q.size(), 0);
    check_output("timeout_tx_valid", bus.tx_valid, 0);
    check_output("timeout_err", bus.err_count, err_model);
    send_byte(8'h00);
    send_byte(8'h11);
    make_packet(8'h57, 8'h01, 8'h02, 8'h77, 8'h00, 1'b0);
    apply_stimulus("resync", 0);
    make_packet(8'h57, 8'h0A, 8'h0B, 8'h55, 8'h00, 1'b0);
    apply_stimulus("slow_bytes", TMO - 1);

    $display("[TB] overrun during EXEC");
    check_output("overrun_before", bus.overrun, 0);
    bus.wr_ready = 1'b0;
    make_packet(8'h46, 8'h20, 8'h00, 8'hE1, 8'h08, 1'b0);
    model_packet();
    wr_q.delete();
    rsp_q.delete();
    foreach (pkt[i]) send_byte(pkt[i]);
    wait_wr_en(20);
    send_byte(8'hA5);
    check_output("overrun_set", bus.overrun, 1);
    bus.wr_ready = 1'b1;
    wait_resp(100);
    compare_result("overrun");

    $display("[TB] response backpressure");
    bus.tx_ready = 1'b0;
    stab_err = 0;
    make_packet(8'h57, 8'h40, 8'h00, 8'h5E, 8'h00, 1'b0);
    model_packet();
    wr_q.delete();
    rsp_q.delete();
    foreach (pkt[i]) send_byte(pkt[i]);
    for (int c = 0; c < 20 && bus.tx_valid !== 1'b1; c++) tick();
    for (int c = 0; c < 20; c++) begin
      check_output("txbp_valid", bus.tx_valid, 1);
      check_output("txbp_data", bus.tx_data, 8'h06);
      tick();
    end
    bus.tx_ready = 1'b1;
    tick();
    check_output("txbp_drop", bus.tx_valid, 0);
    compare_result("txbp");
    check_output("txbp_stable", stab_err, 0);

    $display("[TB] randomized packets");
    rdy_random = 1'b1;
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) rcmd = 8'h57;
      else if (r < 8) rcmd = 8'h46;
      else begin
        rcmd = 8'($urandom);
        if (rcmd == 8'h57 || rcmd == 8'h46) rcmd = 8'h00;
      end
      rn = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 12));
      make_packet(rcmd, 8'($urandom), 8'($urandom), 8'($urandom), rn,
                  $urandom_range(0, 4) == 0);
      apply_stimulus("rand", -1);
    end
    rdy_random = 1'b0;
    bus.wr_ready = 1'b1;
    check_output("rand_hold_err", hold_err, 0);

    $display("[TB] error counter saturation");
    while (err_model < 257) begin
      make_packet(8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      model_packet();
      if (err_model == 255) err_model = 257;
      rsp_q.delete();
      foreach (pkt[i]) send_byte(pkt[i]);
      wait_resp(20);
    end
    check_output("err_saturated", bus.err_count, 255);

    $display("[TB] reset during 256-write fill");
    make_packet(8'h46, 8'h80, 8'h00, 8'hC3, 8'h00, 1'b0);
    wr_q.delete();
    rsp_q.delete();
    foreach (pkt[i]) send_byte(pkt[i]);
    for (int c = 0; c < 40 && wr_q.size() < 10; c++) tick();
    check_output("rst_fill_running", bus.wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_wr_en", bus.wr_en, 0);
    check_output("rst_err", bus.err_count, 0);
    check_output("rst_overrun", bus.overrun, 0);
    check_output("rst_tx_valid", bus.tx_valid, 0);
    tick();
    rst_n = 1'b1;
    err_model = 0;
    repeat (5) tick();
    check_output("rst_no_rsp", rsp_q.size(), 0);
    make_packet(8'h57, 8'h00, 8'h42, 8'h24, 8'h00, 1'b0);
    apply_stimulus("after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
